// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single request/response memory bus.
// One transaction in flight; data port favoured, with a burst cap protecting fetch.
module mem_arbiter #(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 64,
    parameter int MaxMeBurst    = 4
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iIF_req,
    input  logic [AddrWidth-1:0] iIF_addr,
    output logic                 oIF_ack,
    output logic [DataWidth-1:0] oIF_rdata,
    output logic                 oIF_err,
    input  logic                 iME_req,
    input  logic                 iME_we,
    input  logic [3:0]           iME_be,
    input  logic [AddrWidth-1:0] iME_addr,
    input  logic [DataWidth-1:0] iME_wdata,
    output logic                 oME_ack,
    output logic [DataWidth-1:0] oME_rdata,
    output logic                 oME_err,
    output logic                 oMem_valid,
    input  logic                 iMem_ready,
    output logic [AddrWidth-1:0] oMem_addr,
    output logic                 oMem_we,
    output logic [3:0]           oMem_be,
    output logic [DataWidth-1:0] oMem_wdata,
    input  logic                 iMem_rvalid,
    input  logic [DataWidth-1:0] iMem_rdata,
    input  logic                 iMem_err
);

    localparam int CntW = $clog2(MaxMeBurst + 1);
    localparam int TmoW = $clog2(TimeoutCycles + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              r_state;
    logic                r_sel_me;
    logic [CntW-1:0]     r_me_cnt;
    logic [TmoW-1:0]     r_tmo;

    logic                w_burst_full;
    logic                w_me_win;
    logic                w_tmo_hit;
    logic                w_done;
    logic                w_rsp_err;
    logic [DataWidth-1:0] w_rsp_data;

    assign w_burst_full = (r_me_cnt == CntW'(MaxMeBurst));
    assign w_me_win     = iME_req && !(w_burst_full && iIF_req);
    assign w_tmo_hit    = (r_tmo == TmoW'(TimeoutCycles - 1));

    // Completion of the in-flight transfer: bus response, else timeout
    always_comb begin
        w_done     = 1'b0;
        w_rsp_err  = 1'b0;
        w_rsp_data = '0;
        if (r_state == S_WAIT && iMem_rvalid) begin
            w_done     = 1'b1;
            w_rsp_err  = iMem_err;
            w_rsp_data = oMem_we ? '0 : iMem_rdata;
        end else if ((r_state == S_ISSUE || r_state == S_WAIT) && w_tmo_hit) begin
            w_done    = 1'b1;
            w_rsp_err = 1'b1;
        end
    end

    // Arbitration FSM with registered bus and response outputs
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state    <= S_IDLE;
            r_sel_me   <= 1'b0;
            r_me_cnt   <= '0;
            r_tmo      <= '0;
            oIF_ack    <= 1'b0;
            oIF_err    <= 1'b0;
            oIF_rdata  <= '0;
            oME_ack    <= 1'b0;
            oME_err    <= 1'b0;
            oME_rdata  <= '0;
            oMem_valid <= 1'b0;
            oMem_addr  <= '0;
            oMem_we    <= 1'b0;
            oMem_be    <= 4'h0;
            oMem_wdata <= '0;
        end else begin
            oIF_ack <= 1'b0;
            oIF_err <= 1'b0;
            oME_ack <= 1'b0;
            oME_err <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_me_win) begin
                        r_sel_me   <= 1'b1;
                        oMem_addr  <= iME_addr;
                        oMem_we    <= iME_we;
                        oMem_be    <= iME_be;
                        oMem_wdata <= iME_wdata;
                        oMem_valid <= 1'b1;
                        r_tmo      <= '0;
                        r_state    <= S_ISSUE;
                        if (!iIF_req)
                            r_me_cnt <= '0;
                        else if (!w_burst_full)
                            r_me_cnt <= r_me_cnt + CntW'(1);
                    end else if (iIF_req) begin
                        r_sel_me   <= 1'b0;
                        oMem_addr  <= iIF_addr;
                        oMem_we    <= 1'b0;
                        oMem_be    <= 4'hF;
                        oMem_wdata <= '0;
                        oMem_valid <= 1'b1;
                        r_tmo      <= '0;
                        r_me_cnt   <= '0;
                        r_state    <= S_ISSUE;
                    end else begin
                        r_me_cnt <= '0;
                    end
                end
                S_ISSUE, S_WAIT: begin
                    if (w_done) begin
                        oMem_valid <= 1'b0;
                        r_state    <= S_RESP;
                        if (r_sel_me) begin
                            oME_ack   <= 1'b1;
                            oME_err   <= w_rsp_err;
                            oME_rdata <= w_rsp_data;
                        end else begin
                            oIF_ack   <= 1'b1;
                            oIF_err   <= w_rsp_err;
                            oIF_rdata <= w_rsp_data;
                        end
                    end else begin
                        r_tmo <= r_tmo + TmoW'(1);
                        if (r_state == S_ISSUE && iMem_ready) begin
                            oMem_valid <= 1'b0;
                            r_state    <= S_WAIT;
                        end
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency, priority, burst cap,
// write path, timeout and asynchronous reset abort.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        iRst;
    logic        iIF_req;
    logic [31:0] iIF_addr;
    logic        oIF_ack;
    logic [31:0] oIF_rdata;
    logic        oIF_err;
    logic        iME_req;
    logic        iME_we;
    logic [3:0]  iME_be;
    logic [31:0] iME_addr;
    logic [31:0] iME_wdata;
    logic        oME_ack;
    logic [31:0] oME_rdata;
    logic        oME_err;
    logic        oMem_valid;
    logic        iMem_ready;
    logic [31:0] oMem_addr;
    logic        oMem_we;
    logic [3:0]  oMem_be;
    logic [31:0] oMem_wdata;
    logic        iMem_rvalid;
    logic [31:0] iMem_rdata;
    logic        iMem_err;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .iClk(clk), .iRst(iRst),
        .iIF_req(iIF_req), .iIF_addr(iIF_addr),
        .oIF_ack(oIF_ack), .oIF_rdata(oIF_rdata), .oIF_err(oIF_err),
        .iME_req(iME_req), .iME_we(iME_we), .iME_be(iME_be),
        .iME_addr(iME_addr), .iME_wdata(iME_wdata),
        .oME_ack(oME_ack), .oME_rdata(oME_rdata), .oME_err(oME_err),
        .oMem_valid(oMem_valid), .iMem_ready(iMem_ready),
        .oMem_addr(oMem_addr), .oMem_we(oMem_we), .oMem_be(oMem_be),
        .oMem_wdata(oMem_wdata), .iMem_rvalid(iMem_rvalid),
        .iMem_rdata(iMem_rdata), .iMem_err(iMem_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(negedge clk);
    endtask

    task automatic expect_issue(input string tag, input logic [31:0] a);
        int k = 0;
        while (oMem_valid !== 1'b1 && k < 6) begin
            nxt();
            k++;
        end
        chk({tag, "_valid"}, 32'(oMem_valid), 32'd1);
        chk({tag, "_addr"}, oMem_addr, a);
    endtask

    // Entered at an ISSUE-cycle negedge; returns at the RESP negedge
    task automatic serve(input logic [31:0] rd, input logic e);
        iMem_ready = 1'b1;
        nxt();
        iMem_ready  = 1'b0;
        iMem_rvalid = 1'b1;
        iMem_rdata  = rd;
        iMem_err    = e;
        nxt();
        iMem_rvalid = 1'b0;
        iMem_err    = 1'b0;
        iMem_rdata  = 32'h0;
    endtask

    initial begin
        int k;
        iRst = 1'b1;
        iIF_req = 0; iIF_addr = 0;
        iME_req = 0; iME_we = 0; iME_be = 4'hF;
        iME_addr = 0; iME_wdata = 0;
        iMem_ready = 0; iMem_rvalid = 0; iMem_rdata = 0; iMem_err = 0;
        nxt(); nxt();
        chk("rst_valid", 32'(oMem_valid), 32'd0);
        chk("rst_acks", {30'd0, oIF_ack, oME_ack}, 32'd0);
        chk("rst_be", 32'(oMem_be), 32'd0);
        iRst = 1'b0;
        nxt();

        // ME read with minimum latency
        iME_req = 1; iME_addr = 32'h100;
        nxt();
        chk("lat_valid_n1", 32'(oMem_valid), 32'd1);
        chk("lat_addr", oMem_addr, 32'h100);
        chk("lat_we", 32'(oMem_we), 32'd0);
        iMem_ready = 1;
        nxt();
        chk("lat_valid_n2", 32'(oMem_valid), 32'd0);
        iMem_ready = 0; iMem_rvalid = 1; iMem_rdata = 32'hDEADBEEF;
        nxt();
        iMem_rvalid = 0; iMem_rdata = 0;
        chk("lat_ack_n3", 32'(oME_ack), 32'd1);
        chk("lat_rdata", oME_rdata, 32'hDEADBEEF);
        chk("lat_err", 32'(oME_err), 32'd0);
        chk("lat_if_ack", 32'(oIF_ack), 32'd0);
        iME_req = 0;
        nxt();
        chk("lat_ack_pulse", 32'(oME_ack), 32'd0);
        chk("lat_rdata_hold", oME_rdata, 32'hDEADBEEF);

        // Simultaneous requests: ME first, IF next
        iIF_req = 1; iIF_addr = 32'h0;
        iME_req = 1; iME_addr = 32'h200;
        expect_issue("sim_me", 32'h200);
        serve(32'h11111111, 1'b0);
        chk("sim_me_ack", {30'd0, oIF_ack, oME_ack}, 32'd1);
        iME_req = 0;
        expect_issue("sim_if", 32'h0);
        chk("sim_if_be", 32'(oMem_be), 32'hF);
        chk("sim_if_we", 32'(oMem_we), 32'd0);
        serve(32'hCAFEF00D, 1'b0);
        chk("sim_if_ack", {30'd0, oIF_ack, oME_ack}, 32'd2);
        chk("sim_if_rdata", oIF_rdata, 32'hCAFEF00D);

        // ME burst cap with IF pending
        iIF_addr = 32'h40;
        iME_req = 1;
        for (int i = 0; i < 4; i++) begin
            iME_addr = 32'h400 + 32'(i * 4);
            expect_issue($sformatf("burst_me%0d", i), 32'h400 + 32'(i * 4));
            serve(32'hA0 + 32'(i), (i == 1));
            chk($sformatf("burst_ack%0d", i),
                {30'd0, oIF_ack, oME_ack}, 32'd1);
            chk($sformatf("burst_err%0d", i), 32'(oME_err), 32'(i == 1));
            chk($sformatf("burst_rd%0d", i), oME_rdata, 32'hA0 + 32'(i));
        end
        expect_issue("burst_if", 32'h40);
        serve(32'h600DF00D, 1'b0);
        chk("burst_if_ack", {30'd0, oIF_ack, oME_ack}, 32'd2);
        chk("burst_if_rdata", oIF_rdata, 32'h600DF00D);
        iME_req = 0; iIF_req = 0;

        // Timeout: accepted, never answered
        iME_req = 1; iME_addr = 32'h500;
        expect_issue("tmo", 32'h500);
        iMem_ready = 1;
        k = 1;
        while (k < 100) begin
            nxt();
            iMem_ready = 0;
            if (oME_ack === 1'b1) break;
            k++;
        end
        chk("tmo_cycles", 32'(k), 32'd64);
        chk("tmo_ack", 32'(oME_ack), 32'd1);
        chk("tmo_err", 32'(oME_err), 32'd1);
        chk("tmo_rdata", oME_rdata, 32'h0);
        iME_req = 0;
        iMem_rvalid = 1; iMem_rdata = 32'h77;
        nxt(); nxt();
        chk("tmo_late_ack", 32'(oME_ack), 32'd0);
        chk("tmo_late_rd", oME_rdata, 32'h0);
        iMem_rvalid = 0; iMem_rdata = 0;

        // Write with ready held low for three cycles
        iME_req = 1; iME_we = 1; iME_be = 4'b0011;
        iME_addr = 32'h300; iME_wdata = 32'h1234;
        expect_issue("wr", 32'h300);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("wr_hold%0d", i),
                {oMem_valid, oMem_we, 2'b00, oMem_be, oMem_wdata[23:0]},
                {1'b1, 1'b1, 2'b00, 4'b0011, 24'h001234});
            chk($sformatf("wr_addr%0d", i), oMem_addr, 32'h300);
            nxt();
        end
        serve(32'hFFFFFFFF, 1'b0);
        chk("wr_ack", 32'(oME_ack), 32'd1);
        chk("wr_rdata", oME_rdata, 32'h0);
        iME_req = 0; iME_we = 0; iME_be = 4'hF; iME_wdata = 0;

        // Reset while waiting for the response
        iME_req = 1; iME_addr = 32'h600;
        expect_issue("rst_mid", 32'h600);
        iMem_ready = 1;
        nxt();
        iMem_ready = 0;
        iRst = 1;
        #1;
        chk("rstm_valid", 32'(oMem_valid), 32'd0);
        chk("rstm_addr", oMem_addr, 32'h0);
        chk("rstm_if_rd", oIF_rdata, 32'h0);
        chk("rstm_acks", {29'd0, oIF_ack, oME_ack, oMem_we}, 32'd0);
        iME_req = 0;
        nxt();
        iRst = 0;
        iMem_rvalid = 1; iMem_rdata = 32'hBAD;
        nxt(); nxt();
        chk("rstm_no_ack", {30'd0, oIF_ack, oME_ack}, 32'd0);
        iMem_rvalid = 0; iMem_rdata = 0;
        iME_req = 1; iME_addr = 32'h700;
        expect_issue("post_rst", 32'h700);
        serve(32'h5A5A5A5A, 1'b0);
        chk("post_rst_ack", 32'(oME_ack), 32'd1);
        chk("post_rst_rd", oME_rdata, 32'h5A5A5A5A);
        iME_req = 0;
        nxt();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AddrWidth, 32, byte address width of all ports.
REQ-002 Parameter DataWidth, 32, data width of all ports.
REQ-003 Parameter TimeoutCycles, 64, max cycles in ISSUE+WAIT before an error response.
REQ-004 Parameter MaxMeBurst, 4, consecutive ME grants allowed while an IF request is pending.
REQ-005 One clock and an asynchronous, active-high reset: iClk input 1, clock (all state on rising edge); iRst input 1, asynchronous active-high reset.
REQ-006 Fetch port: iIF_req input 1, fetch request; iIF_addr input AddrWidth, fetch address; oIF_ack output 1, one-cycle completion pulse; oIF_rdata output DataWidth, fetched word; oIF_err output 1, error qualifier valid with oIF_ack.
REQ-007 Data port: iME_req input 1, data request; iME_we input 1, write enable; iME_be input 4, byte enables; iME_addr input AddrWidth, address; iME_wdata input DataWidth, write data; oME_ack output 1, completion pulse; oME_rdata output DataWidth, read data; oME_err output 1, error qualifier.
REQ-008 Memory port: oMem_valid output 1, request valid; iMem_ready input 1, request accepted; oMem_addr output AddrWidth; oMem_we output 1; oMem_be output 4; oMem_wdata output DataWidth; iMem_rvalid input 1, response valid (reads and writes); iMem_rdata input DataWidth; iMem_err input 1, bus error with iMem_rvalid.

Function
REQ-009 FSM states: IDLE, ISSUE, WAIT, RESP; exactly one transaction in flight.
REQ-010 IDLE: iME_req or iIF_req high -> grant, latch requester's addr/we/be/wdata (IF: we=0, be=4'hF, wdata=0), go ISSUE next cycle.
REQ-011 Priority: ME wins when both request, unless the consecutive-ME counter equals MaxMeBurst and iIF_req is high; then IF wins.
REQ-012 Consecutive-ME counter: +1 per ME grant while iIF_req high, saturates at MaxMeBurst, clears on any IF grant or any IDLE cycle with iIF_req low.
REQ-013 ISSUE: oMem_valid=1 with latched fields stable; iMem_ready high -> WAIT next cycle.
REQ-014 WAIT: oMem_valid=0; iMem_rvalid high -> capture iMem_rdata (0 for writes) and iMem_err, go RESP.
REQ-015 RESP (one cycle): granted port's ack=1, err=captured error; rdata outputs hold last captured value until the next ack on that port; next state IDLE; requests ignored in RESP.
REQ-016 Minimum latency: request seen in IDLE at cycle N, ready at N+1, rvalid at N+2 -> ack at N+3; next grant earliest N+4.
REQ-017 Timeout counter clears on grant, increments each cycle in ISSUE and WAIT; reaching TimeoutCycles-1 without completion -> RESP with err=1, rdata=0, oMem_valid dropped.
REQ-018 iMem_rvalid outside WAIT is ignored; iMem_ready outside ISSUE is ignored.
REQ-019 Requesters hold req and fields until ack; requests dropped before grant are ignored; deassertion after grant does not abort.
REQ-020 oIF_ack and oME_ack are never high in the same cycle.

Reset
REQ-021 iRst high: state=IDLE, counters=0, all outputs 0 (acks, errs, rdata, oMem_*), immediately and asynchronously.
REQ-022 Reset mid-transaction aborts it without ack; memory responses arriving after release are ignored per REQ-018.

Verification
REQ-023 ME read addr 0x100, ready same cycle, rvalid next with rdata 0xDEADBEEF -> oME_ack at N+3, oME_rdata=0xDEADBEEF, oME_err=0.
REQ-024 Simultaneous IF (0x0) and ME (0x200) -> ME granted first; IF granted at first IDLE after ME ack.
REQ-025 IF pending with continuous back-to-back ME requests -> IF granted after exactly 4 ME grants.
REQ-026 ME write 0x300 be=4'b0011, wdata 0x1234 -> oMem_we=1, oMem_be=0011, fields stable across 3 ready-low cycles; ack after rvalid.
REQ-027 No rvalid after acceptance -> oME_ack with oME_err=1 and oME_rdata=0 at the 64th ISSUE+WAIT cycle; later rvalid ignored.
REQ-028 iRst pulse while in WAIT -> all outputs 0 same cycle, no ack, next request served normally.
